nvdla_glb_csb_req_bridge: RTL



---
 rtl/nvdla_glb_csb_pkg.sv | 26 ++
 rtl/nvdla_glb_csb_req_bridge_if.sv | 22 ++
 rtl/nvdla_glb_csb_resp_fifo.sv | 54 +++++
 rtl/nvdla_glb_csb_req_bridge.sv | 101 ++++++++++
 4 files changed

// File: rtl/nvdla_glb_csb_pkg.sv
// Shared field positions, widths and response encodings for the CSB-to-GLB request bridge.
package nvdla_glb_csb_pkg;

    localparam int unsigned REQ_PD_W  = 63;
    localparam int unsigned RESP_PD_W = 34;

    localparam int unsigned ADDR_LSB     = 0;
    localparam int unsigned ADDR_MSB     = 21;
    localparam int unsigned ADDR_SEL_LSB = 10;
    localparam int unsigned WDAT_LSB     = 22;
    localparam int unsigned WDAT_MSB     = 53;
    localparam int unsigned WRITE_BIT    = 54;
    localparam int unsigned NPOSTED_BIT  = 55;
    localparam int unsigned WRBE_LSB     = 57;
    localparam int unsigned WRBE_MSB     = 60;

    localparam logic RESP_TYPE_RD = 1'b0;
    localparam logic RESP_TYPE_WR = 1'b1;

    typedef struct packed {
        logic        resp_type;
        logic        error;
        logic [31:0] rdata;
    } resp_pd_t;

endpackage

// File: rtl/nvdla_glb_csb_req_bridge_if.sv
// CSB request/response channel between the fabric (master) and the GLB bridge (slave).
interface nvdla_glb_csb_req_bridge_if;
    import nvdla_glb_csb_pkg::*;

    logic                 csb2glb_req_pvld;
    logic                 csb2glb_req_prdy;
    logic [REQ_PD_W-1:0]  csb2glb_req_pd;
    logic                 glb2csb_resp_valid;
    logic                 glb2csb_resp_ready;
    logic [RESP_PD_W-1:0] glb2csb_resp_pd;

    modport master (
        output csb2glb_req_pvld, csb2glb_req_pd, glb2csb_resp_ready,
        input  csb2glb_req_prdy, glb2csb_resp_valid, glb2csb_resp_pd
    );

    modport slave (
        input  csb2glb_req_pvld, csb2glb_req_pd, glb2csb_resp_ready,
        output csb2glb_req_prdy, glb2csb_resp_valid, glb2csb_resp_pd
    );

endinterface

// File: rtl/nvdla_glb_csb_resp_fifo.sv
// Flop-based in-order response buffer; a push into a full buffer is legal only alongside a pop.
module nvdla_glb_csb_resp_fifo
    import nvdla_glb_csb_pkg::*;
#(
    parameter  int unsigned Depth = 2,
    localparam int unsigned PtrW  = $clog2(Depth),
    localparam int unsigned CntW  = $clog2(Depth + 1)
) (
    input  logic            nvdla_core_clk,
    input  logic            nvdla_core_rstn,
    input  logic            push_i,
    input  logic            pop_i,
    input  resp_pd_t        wdata_i,
    output resp_pd_t        rdata_o,
    output logic [CntW-1:0] count_o,
    output logic            empty_o
);

    resp_pd_t        mem_q [Depth];
    logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0] cnt_q;
    logic            do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop = pop_i & (cnt_q != '0);

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            cnt_q <= cnt_q + CntW'(push_i) - CntW'(do_pop);
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = cnt_q;
    assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/nvdla_glb_csb_req_bridge.sv
// CSB request to GLB register-port bridge: one-entry access stage, block decode,
// buffered read/non-posted-write responses with credit-based request flow control.
module nvdla_glb_csb_req_bridge
    import nvdla_glb_csb_pkg::*;
#(
    parameter logic [11:0] BLK_BASE         = 12'h000,
    parameter bit          RESP_ERR_ON_MISS = 1'b1,
    parameter int unsigned RESP_DEPTH       = 2
) (
    input  logic                      nvdla_core_clk,
    input  logic                      nvdla_core_rstn,
    nvdla_glb_csb_req_bridge_if.slave csb,
    output logic [11:0]               reg_offset,
    output logic [31:0]               reg_wr_data,
    output logic                      reg_wr_en,
    input  logic [31:0]               reg_rd_data
);

    localparam int unsigned CntW       = $clog2(RESP_DEPTH + 1);
    localparam logic [CntW:0] RespDepthW = (CntW + 1)'(RESP_DEPTH);

    logic [REQ_PD_W-1:0] req_pd;
    logic                req_acc;
    logic                unused_req_bits;

    logic        stage_vld_q, stage_write_q, stage_nposted_q, stage_hit_q;
    logic        stage_needs_resp;
    logic [11:0] reg_offset_q;
    logic [31:0] reg_wr_data_q;

    logic            resp_push, resp_pop, resp_empty;
    logic [CntW-1:0] resp_cnt;
    logic [CntW:0]   resp_used;
    resp_pd_t        resp_wdata, resp_rdata;

    assign req_pd          = csb.csb2glb_req_pd;
    assign unused_req_bits = ^req_pd[REQ_PD_W-1:NPOSTED_BIT+1];
    assign req_acc         = csb.csb2glb_req_pvld & csb.csb2glb_req_prdy;

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            stage_vld_q     <= 1'b0;
            stage_write_q   <= 1'b0;
            stage_nposted_q <= 1'b0;
            stage_hit_q     <= 1'b0;
            reg_offset_q    <= '0;
            reg_wr_data_q   <= '0;
        end else begin
            stage_vld_q <= req_acc;
            if (req_acc) begin
                stage_write_q   <= req_pd[WRITE_BIT];
                stage_nposted_q <= req_pd[NPOSTED_BIT];
                stage_hit_q     <= (req_pd[ADDR_MSB:ADDR_SEL_LSB] == BLK_BASE);
                reg_offset_q    <= {req_pd[ADDR_SEL_LSB-1:ADDR_LSB], 2'b00};
                reg_wr_data_q   <= req_pd[WDAT_MSB:WDAT_LSB];
            end
        end
    end

    assign reg_offset  = reg_offset_q;
    assign reg_wr_data = reg_wr_data_q;
    assign reg_wr_en   = stage_vld_q & stage_write_q & stage_hit_q;

    // Read data is captured into the buffer at the end of the access cycle.
    always_comb begin
        resp_wdata = '0;
        if (stage_write_q) begin
            resp_wdata.resp_type = RESP_TYPE_WR;
        end else begin
            resp_wdata.resp_type = RESP_TYPE_RD;
            resp_wdata.error     = ~stage_hit_q & RESP_ERR_ON_MISS;
            resp_wdata.rdata     = stage_hit_q ? reg_rd_data : 32'h0;
        end
    end

    assign stage_needs_resp = ~stage_write_q | stage_nposted_q;
    assign resp_push        = stage_vld_q & stage_needs_resp;
    assign resp_pop         = ~resp_empty & csb.glb2csb_resp_ready;

    nvdla_glb_csb_resp_fifo #(
        .Depth (RESP_DEPTH)
    ) u_resp_fifo (
        .nvdla_core_clk  (nvdla_core_clk),
        .nvdla_core_rstn (nvdla_core_rstn),
        .push_i          (resp_push),
        .pop_i           (resp_pop),
        .wdata_i         (resp_wdata),
        .rdata_o         (resp_rdata),
        .count_o         (resp_cnt),
        .empty_o         (resp_empty)
    );

    // Slots committed to responses; ready whenever at least one slot is free (credit != 0).
    assign resp_used = {1'b0, resp_cnt} + {{CntW{1'b0}}, resp_push}
                       - {{CntW{1'b0}}, resp_pop};

    assign csb.csb2glb_req_prdy   = (resp_used < RespDepthW);
    assign csb.glb2csb_resp_valid = ~resp_empty;
    assign csb.glb2csb_resp_pd    = resp_rdata;

endmodule
